data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Parametrised successor to the single-cycle data memory. It serves global-data, stack and peripheral pages over a request/ready handshake with configurable wait states. It supports byte, halfword and word accesses with little-endian lane steering and sign or zero extension. Faulting accesses are reported per transaction and captured in a sticky error register. It sits between the CPU MEM stage and the on-chip RAM and peripheral bus.

Parameters:
GLOBAL_WORDS, 32, number of 32-bit words in the global region, range 1..1024
STACK_WORDS, 32, number of 32-bit words in the stack region, at the top of its page, range 1..1024
GLOBAL_PAGE, 19'h10010, value of addr[30:12] selecting the global region (region starts at word 0 of the page)
STACK_PAGE, 19'h7FFFF, value of addr[30:12] selecting the stack region
PERI_PAGE, 19'h40000, value of addr[30:12] selecting the peripheral page
WAIT_CYCLES, 0, extra BUSY cycles before completion, range 0..15

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  1  request strobe; sampled only in IDLE
wr  in  1  1 = write, 0 = read; latched with req
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal; latched with req
sign_ext  in  1  1 = sign-extend sub-word reads; latched with req
addr  in  32  byte address; latched with req
wdata  in  32  write data, right-aligned for sub-word; latched with req
rdata  out  32  read result; valid while ready=1
ready  out  1  one-cycle completion pulse
err_resp  out  1  1 with ready when the transaction faulted
err_flag  out  1  sticky error flag
err_addr  out  32  address of the first fault since the last clear
err_clr  in  1  clears err_flag (synchronous)
peri_rd  out  1  peripheral read strobe
peri_wr  out  1  peripheral write strobe
peri_addr  out  32  latched address to the peripheral
peri_wdata  out  32  latched write data to the peripheral
peri_rdata  in  32  peripheral read data (combinational)
peri_acc  in  1  peripheral reports the address as valid

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ready, err_resp, err_flag, peri_rd, peri_wr = 0; rdata, err_addr, peri_addr, peri_wdata, wait counter = 0. RAM contents are not reset.
- Reset mid-transaction: the access is aborted and no RAM write occurs.
- FSM IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: on req=1, latch wr, size, sign_ext, addr, wdata; load counter=WAIT_CYCLES; go to BUSY.
  - BUSY: while counter != 0, decrement. At the edge where counter == 0, perform the access and go to RESP.
  - RESP: ready=1 for exactly one cycle, then IDLE.
- Latency: with the accepting edge as E0, ready is high in the cycle after edge E0+WAIT_CYCLES+1. req outside IDLE is ignored, including during RESP.
- Decode uses the latched address. addr[31] is ignored; page = addr[30:12]; word index = addr[11:2].
  - Global region: index < GLOBAL_WORDS.
  - Stack region: index >= 1024-STACK_WORDS.
  - Peripheral page: forwarded to the peripheral port.
- Faults (any of the following): size=11; halfword with addr[0]=1; word with addr[1:0]!=0; unmapped page; index outside the region; peripheral access with size!=10; peripheral peri_acc=0.
- On a fault:
  - No RAM write occurs.
  - rdata=32'hCDCDCDCD, err_resp=1 in RESP.
  - If err_flag=0, set err_flag and capture err_addr=addr.
  - If err_flag=1, err_addr holds.
- err_clr: clears err_flag in any state. If err_clr and a new fault occur on the same edge, the fault wins: flag stays 1 and err_addr is recaptured.
- Lane steering (little-endian):
  - Byte write stores wdata[7:0] into lane addr[1:0]. Halfword write stores wdata[15:0] into lanes {addr[1],0}..{addr[1],1}. Other lanes are unchanged.
  - Reads extract the same lanes, then sign-extend from bit 7/15 when sign_ext=1, otherwise zero-extend. Word reads return the full word.
- Peripheral path: peri_rd/peri_wr are high only during the final BUSY cycle (counter == 0) of a word-size peripheral access. peri_addr/peri_wdata hold the latched values. peri_rdata and peri_acc are sampled at the completion edge.
- rdata for successful writes = 0. rdata holds its value outside RESP; consumers sample only on ready.

Test Plan:
- WAIT_CYCLES=0: req word write 0x10010004 <= 0xDEADBEEF, then word read of the same address -> each ready exactly 2 cycles after req edge; rdata=0xDEADBEEF, err_resp=0.
- Byte write 0x80 to 0x10010006, then reads: lbu -> 0x00000080; lb -> 0xFFFFFF80; word read -> 0xDE80BEEF.
- Halfword read at 0x10010005 -> err_resp=1, rdata=0xCDCDCDCD, err_flag=1, err_addr=0x10010005. A later fault at 0x20000000 leaves err_addr unchanged. err_clr asserted together with a fault at 0x7FFFF000 -> err_flag=1, err_addr=0x7FFFF000.
- WAIT_CYCLES=3, stack word write 0x7FFFFFFC <= 0x12345678 -> ready 5 cycles after accept; a req held high during BUSY/RESP does not start a second access; readback = 0x12345678.
- Peripheral read 0x40000010 with peri_acc=1, peri_rdata=0xA5A5A5A5 -> peri_rd is a 1-cycle pulse, rdata=0xA5A5A5A5. The same access with peri_acc=0 -> err_resp=1. A byte peripheral write -> peri_wr stays 0 and err_resp=1.
- reset_n pulled low in BUSY of a write to 0x10010000 (old value 0x11111111) -> outputs return to reset values; a read after reset returns 0x11111111.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: banked data memory for the MEM stage.
// Serves a global-data region, a stack region at the top of its page and a
// forwarded peripheral page over a req/ready handshake with WAIT_CYCLES extra
// busy cycles. Sub-word accesses are little-endian lane-steered with optional
// sign extension. Faults complete with a poisoned read value and are captured
// in a sticky error register.
module data_mem_ctrl #(
    parameter int          GLOBAL_WORDS = 32,
    parameter int          STACK_WORDS  = 32,
    parameter logic [18:0] GLOBAL_PAGE  = 19'h10010,
    parameter logic [18:0] STACK_PAGE   = 19'h7FFFF,
    parameter logic [18:0] PERI_PAGE    = 19'h40000,
    parameter int          WAIT_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err_resp,
    output logic        err_flag,
    output logic [31:0] err_addr,
    input  logic        err_clr,
    output logic        peri_rd,
    output logic        peri_wr,
    output logic [31:0] peri_addr,
    output logic [31:0] peri_wdata,
    input  logic [31:0] peri_rdata,
    input  logic        peri_acc
);

    localparam int          GAW        = (GLOBAL_WORDS > 1) ? $clog2(GLOBAL_WORDS) : 1;
    localparam int          SAW        = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;
    localparam logic [9:0]  STACK_BASE = 10'(1024 - STACK_WORDS);
    localparam logic [10:0] GLOBAL_LIM = 11'(GLOBAL_WORDS);
    localparam logic [31:0] POISON     = 32'hCDCDCDCD;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_accept, w_done;

    logic        r_wr, r_sext;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    logic [31:0] r_rdata, r_err_addr;
    logic        r_ready, r_err_resp, r_err_flag;

    logic [31:0] r_gmem [GLOBAL_WORDS];
    logic [31:0] r_smem [STACK_WORDS];

    logic [18:0]    w_page;
    logic [9:0]     w_idx;
    logic [GAW-1:0] w_gidx;
    logic [SAW-1:0] w_sidx;
    logic           w_hit_glb, w_hit_stk, w_hit_peri, w_peri_ok;
    logic           w_misalign, w_fault, w_ram_we;
    logic [31:0]    w_src, w_rd_ext, w_wlane;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [3:0]     w_be;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: accept in IDLE only, count down in BUSY, one RESP cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (req) begin
                w_accept    = 1'b1;
                w_state_nxt = S_BUSY;
                w_cnt_nxt   = 4'(WAIT_CYCLES);
            end
            S_BUSY: if (r_cnt == 4'd0) begin
                w_done      = 1'b1;
                w_state_nxt = S_RESP;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request; these also drive the peripheral address/data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= 1'b0;
            r_sext  <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_wr    <= wr;
            r_sext  <= sign_ext;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Decode of the latched address; bit 31 is not part of the page
    assign w_page     = r_addr[30:12];
    assign w_idx      = r_addr[11:2];
    assign w_gidx     = GAW'(w_idx);
    assign w_sidx     = SAW'(w_idx - STACK_BASE);
    assign w_hit_glb  = (w_page == GLOBAL_PAGE) && ({1'b0, w_idx} < GLOBAL_LIM);
    assign w_hit_stk  = (w_page == STACK_PAGE) && (w_idx >= STACK_BASE);
    assign w_hit_peri = (w_page == PERI_PAGE);
    assign w_misalign = (r_size == 2'b11) ||
                        (r_size == 2'b01 && r_addr[0]) ||
                        (r_size == 2'b10 && r_addr[1:0] != 2'b00);
    // Peripherals only take aligned word accesses
    assign w_peri_ok  = w_hit_peri && (r_size == 2'b10) && (r_addr[1:0] == 2'b00);
    assign w_fault    = w_misalign || !(w_hit_glb || w_hit_stk || w_hit_peri) ||
                        (w_hit_peri && !(w_peri_ok && peri_acc));
    assign w_ram_we   = w_done && r_wr && !w_fault;

    // Strobes live only in the final BUSY cycle of a legal peripheral access
    assign peri_rd    = (r_state == S_BUSY) && (r_cnt == 4'd0) && w_peri_ok && !r_wr;
    assign peri_wr    = (r_state == S_BUSY) && (r_cnt == 4'd0) && w_peri_ok && r_wr;
    assign peri_addr  = r_addr;
    assign peri_wdata = r_wdata;

    // Read lane steering and extension
    always_comb begin
        w_src = r_smem[w_sidx];
        if (w_hit_peri)
            w_src = peri_rdata;
        else if (w_hit_glb)
            w_src = r_gmem[w_gidx];
        w_byte = w_src[{r_addr[1:0], 3'b000} +: 8];
        w_half = w_src[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_rd_ext = r_sext ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'b01:   w_rd_ext = r_sext ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_rd_ext = w_src;
        endcase
    end

    // Write lane enables with the write data replicated across lanes
    always_comb begin
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // RAM banks; contents survive reset, and reset forces IDLE so no write lands
    always_ff @(posedge clk) begin
        if (w_ram_we && w_hit_glb) begin
            for (int l = 0; l < 4; l++)
                if (w_be[l]) r_gmem[w_gidx][8*l +: 8] <= w_wlane[8*l +: 8];
        end else if (w_ram_we && w_hit_stk) begin
            for (int l = 0; l < 4; l++)
                if (w_be[l]) r_smem[w_sidx][8*l +: 8] <= w_wlane[8*l +: 8];
        end
    end

    // Completion response; rdata holds between transactions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready    <= 1'b0;
            r_err_resp <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_ready    <= w_done;
            r_err_resp <= w_done && w_fault;
            if (w_done)
                r_rdata <= w_fault ? POISON : (r_wr ? 32'd0 : w_rd_ext);
        end
    end

    // Sticky error; a fault beats a simultaneous clear and recaptures the address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_flag <= 1'b0;
            r_err_addr <= 32'd0;
        end else if (w_done && w_fault) begin
            r_err_flag <= 1'b1;
            if (!r_err_flag || err_clr) r_err_addr <= r_addr;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
        end
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign err_resp = r_err_resp;
    assign err_flag = r_err_flag;
    assign err_addr = r_err_addr;

endmodule
